// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch PC unit: FSM encodings,
// default address-map constants and the branch-offset helper.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10,
    ST_BAD   = 2'b11
  } ifu_state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int unsigned DEF_IM_WORDS = 4096;

  // Word offset to byte offset: sign-extend imm16, then shift left by two.
  function automatic logic [31:0] sext_shl2(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection for the fetch unit; purely combinational.
// Redirect priority is jr, then j/jal, then taken branch, then pc+4.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] adr,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic [31:0] pc4
);

  assign pc4 = adr + 32'd4;

  always_comb begin
    next_pc = pc4;
    if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = {pc4[31:28], jump_idx, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc4 + sext_shl2(branch_off);
    end
  end

endmodule

// File: rtl/ifu_pc.sv
// Instruction-fetch PC register with RUN/HALT/FAULT control and fetch-range trap.
// Defining IFU_FETCH_CNT_EN adds the fetch_cnt output and its counter.
module ifu_pc
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int unsigned IM_WORDS = DEF_IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_off,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic [31:0] adr,
  output logic [31:0] pc4,
  output logic [1:0]  state,
`ifdef IFU_FETCH_CNT_EN
  output logic [31:0] fetch_cnt,
`endif
  output logic        pc_err
);

  // One past the last legal byte address, kept 33 bits wide so a range
  // ending exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] adr_reg;
  logic [31:0] next_pc;
  ifu_state_t  state_reg;
  logic        pc_err_reg;
  logic        target_ok;
  logic        adr_update;

  ifu_npc u_npc (
    .adr          (adr_reg),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .jr           (jr),
    .jr_target    (jr_target),
    .next_pc      (next_pc),
    .pc4          (pc4)
  );

  assign target_ok  = (next_pc[1:0] == 2'b00) && (next_pc >= IM_BASE) &&
                      ({1'b0, next_pc} < IM_END);
  assign adr_update = (state_reg == ST_RUN) && !halt && !stall && target_ok;

  always_ff @(posedge clk) begin
    if (!reset) begin
      adr_reg    <= RESET_PC;
      state_reg  <= ST_RUN;
      pc_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (halt) begin
            state_reg <= ST_HALT;
          end else if (!stall) begin
            if (target_ok) begin
              adr_reg <= next_pc;
            end else begin
              state_reg  <= ST_FAULT;
              pc_err_reg <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        // ST_FAULT and the unreachable encoding both hold the trap
        default: begin
          pc_err_reg <= 1'b1;
        end
      endcase
    end
  end

  assign adr    = adr_reg;
  assign state  = state_reg;
  assign pc_err = pc_err_reg;

`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_reg <= 32'd0;
    end else if (adr_update) begin
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_reg;
`endif

endmodule

// File: tb/tb_ifu_pc.sv
// Scoreboard bench for ifu_pc: the driver queues the expected post-edge state
// for every cycle it drives; a monitor pops and compares after each edge.
module tb_ifu_pc;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] F = 2'b10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_off = 16'h0;
  logic        jump = 1'b0;
  logic [25:0] jump_idx = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        halt = 1'b0;
  logic [31:0] adr;
  logic [31:0] pc4;
  logic [1:0]  state;
  logic        pc_err;
`ifdef IFU_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  ifu_pc dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .jump         (jump),
    .jump_idx     (jump_idx),
    .jr           (jr),
    .jr_target    (jr_target),
    .halt         (halt),
    .adr          (adr),
    .pc4          (pc4),
    .state        (state),
`ifdef IFU_FETCH_CNT_EN
    .fetch_cnt    (fetch_cnt),
`endif
    .pc_err       (pc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] adr;
    logic [1:0]  st;
    logic        err;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t m;
  logic cnt_bad;

  always @(posedge clk) begin
    edge_n++;
    #2;
    while (q.size() > 0 && q[0].cyc <= edge_n) begin
      m = q.pop_front();
      n_chk++;
      cnt_bad = 1'b0;
`ifdef IFU_FETCH_CNT_EN
      cnt_bad = (fetch_cnt !== m.cnt);
`endif
      if (m.cyc != edge_n || adr !== m.adr || pc4 !== (m.adr + 32'd4) ||
          state !== m.st || pc_err !== m.err || cnt_bad) begin
        n_fail++;
        $display("FAIL %s edge %0d: got adr=%h pc4=%h st=%0d err=%0d, want adr=%h pc4=%h st=%0d err=%0d (cnt mismatch=%0d, exp edge %0d)",
                 m.name, edge_n, adr, pc4, state, pc_err,
                 m.adr, m.adr + 32'd4, m.st, m.err, cnt_bad, m.cyc);
      end else begin
        $display("txn edge %0d %s: adr=%h st=%0d err=%0d", edge_n, m.name, adr, state, pc_err);
      end
    end
  end

  // Queue the expectation for the next edge, let it happen, then drop strobes.
  task automatic tick(input string nm, input logic [31:0] ea, input logic [1:0] es,
                      input logic ee, input logic [31:0] ec);
    exp_t e;
    e.cyc = edge_n + 1;
    e.adr = ea;
    e.st = es;
    e.err = ee;
    e.cnt = ec;
    e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    jump = 1'b0;
    jr = 1'b0;
    halt = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required end before it", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset and sequential fetch
    reset = 1'b0; tick("reset0", 32'h3000, R, 0, 0);
    reset = 1'b0; tick("reset1", 32'h3000, R, 0, 0);
    tick("seq1", 32'h3004, R, 0, 1);
    tick("seq2", 32'h3008, R, 0, 2);
    tick("seq3", 32'h300C, R, 0, 3);

    // 2: branches forward and backward from 0x3008
    jr = 1; jr_target = 32'h3008; tick("jr3008a", 32'h3008, R, 0, 4);
    branch_taken = 1; branch_off = 16'hFFFE; tick("br_back", 32'h3004, R, 0, 5);
    jr = 1; jr_target = 32'h3008; tick("jr3008b", 32'h3008, R, 0, 6);
    branch_taken = 1; branch_off = 16'h0003; tick("br_fwd", 32'h3018, R, 0, 7);

    // 3: jumps and priority
    jump = 1; jump_idx = 26'h0000C10; tick("jump", 32'h3040, R, 0, 8);
    jump = 1; jr = 1; jr_target = 32'h3100; tick("jr_over_j", 32'h3100, R, 0, 9);
    jump = 1; branch_taken = 1; branch_off = 16'h0005; tick("j_over_br", 32'h3040, R, 0, 10);

    // 5: stall drops redirects; halt beats stall and an illegal target
    repeat (3) begin
      stall = 1; branch_taken = 1; branch_off = 16'h0003; tick("stall_br", 32'h3040, R, 0, 10);
    end
    tick("seq_after_stall", 32'h3044, R, 0, 11);
    stall = 1; jr = 1; jr_target = 32'h3001; tick("stall_bad_jr", 32'h3044, R, 0, 11);
    halt = 1; stall = 1; jr = 1; jr_target = 32'h7000; tick("halt", 32'h3044, H, 0, 11);
    jr = 1; jr_target = 32'h3100; tick("halt_hold", 32'h3044, H, 0, 11);
    reset = 0; tick("reset_halt", 32'h3000, R, 0, 0);

    // 4: misaligned and out-of-range targets trap
    jr = 1; jr_target = 32'h3001; tick("misalign", 32'h3000, F, 1, 0);
    jr = 1; jr_target = 32'h3100; tick("fault_jr", 32'h3000, F, 1, 0);
    halt = 1; tick("fault_halt", 32'h3000, F, 1, 0);
    tick("fault_seq", 32'h3000, F, 1, 0);
    branch_taken = 1; branch_off = 16'h0004; tick("fault_br", 32'h3000, F, 1, 0);
    jump = 1; jump_idx = 26'h0000C10; tick("fault_j", 32'h3000, F, 1, 0);
    reset = 0; tick("reset_fault", 32'h3000, R, 0, 0);
    jr = 1; jr_target = 32'h6FFC; tick("last_word", 32'h6FFC, R, 0, 1);
    tick("past_end", 32'h6FFC, F, 1, 1);
    reset = 0; tick("reset_end", 32'h3000, R, 0, 0);
    jr = 1; jr_target = 32'h7000; tick("jr7000", 32'h3000, F, 1, 0);
    reset = 0; tick("reset_7000", 32'h3000, R, 0, 0);
    jr = 1; jr_target = 32'h2FFC; tick("below_base", 32'h3000, F, 1, 0);
    reset = 0; tick("reset_base", 32'h3000, R, 0, 0);

    // 6: ten RUN cycles, two of them stalled
    tick("run1", 32'h3004, R, 0, 1);
    tick("run2", 32'h3008, R, 0, 2);
    stall = 1; tick("run3_stall", 32'h3008, R, 0, 2);
    tick("run4", 32'h300C, R, 0, 3);
    tick("run5", 32'h3010, R, 0, 4);
    tick("run6", 32'h3014, R, 0, 5);
    stall = 1; tick("run7_stall", 32'h3014, R, 0, 5);
    tick("run8", 32'h3018, R, 0, 6);
    tick("run9", 32'h301C, R, 0, 7);
    tick("run10", 32'h3020, R, 0, 8);
`ifdef IFU_FETCH_CNT_EN
    #2;
    force dut.fetch_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_reg;
    tick("cnt_wrap", 32'h3024, R, 0, 0);
    tick("cnt_after_wrap", 32'h3028, R, 0, 1);
`endif

    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_pc.md
Name: ifu_pc

Overview:
- Instruction-fetch PC unit for the single-cycle MIPS datapath.
- Sits directly upstream of the instruction memory: drives the word address the memory decodes into `instr`.
- Computes next-PC from decoder/ALU redirect inputs (sequential, beq-type branch, j/jal, jr).
- Holds the PC on stall, freezes on halt, and traps on illegal fetch targets.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_WORDS, 4096, instruction memory depth in words; legal range is [IM_BASE, IM_BASE + 4*IM_WORDS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hold PC this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_off  in  16  branch imm16 (word offset, signed).
- jump  in  1  j/jal redirect.
- jump_idx  in  26  j/jal instr_index field.
- jr  in  1  jr/jalr redirect.
- jr_target  in  32  register-sourced target.
- halt  in  1  stop fetching.
- adr  out  32  current PC, to instruction memory.
- pc4  out  32  adr+4, link value for jal.
- state  out  2  FSM state.
- pc_err  out  1  sticky fetch fault.

Behaviour:
- Reset is synchronous and active-low. When reset==0 at a clk edge: adr=RESET_PC, state=RUN, pc_err=0. Reset overrides every other input, including mid-stall, HALT and FAULT.
- pc4 is combinational adr+4, with mod-2^32 wrap.
- Next-PC priority: jr > jump > branch_taken > sequential.
  - jr: jr_target.
  - jump: {pc4[31:28], jump_idx, 2'b00}.
  - branch: pc4 + (signext(branch_off) << 2), 32-bit wrap.
  - sequential: pc4.
- States: RUN=2'b00, HALT=2'b01, FAULT=2'b10. 2'b11 is unreachable and is treated as FAULT.
- RUN, per edge:
  - halt=1: go to HALT, adr unchanged. halt beats stall and fault.
  - else stall=1: adr held and redirects are dropped. The controller must re-present them.
  - else if next-PC is misaligned (bits[1:0]!=0) or outside the legal range: go to FAULT, adr held, pc_err=1.
  - else adr <= next-PC.
- HALT: adr frozen, all inputs ignored, sticky until reset.
- FAULT: adr frozen, pc_err=1, sticky until reset.
- Latency: a redirect presented in cycle n appears on adr in cycle n+1. No bubble.

Optional Feature:
- Macro IFU_FETCH_CNT_EN. When defined, adds output fetch_cnt (32) and a counter register.
  - Counter resets to 0.
  - It increments on each edge where adr is updated in RUN.
  - It does not count stall, HALT or FAULT cycles.
  - It wraps at 2^32.
- When undefined, neither the port nor the logic exists, and behaviour is otherwise identical.

Decomposition:
- Package ifu_pkg holds:
  - state encodings ST_RUN / ST_HALT / ST_FAULT;
  - default RESET_PC and IM_BASE constants;
  - the sign-extend-shift function.
- One natural combinational sub-module, ifu_npc, with inputs adr, redirect controls and fields; outputs next_pc and pc4.
- ifu_pc owns the PC register, the FSM, range checking and the optional counter.

Test Plan:
1. reset=0 for 2 edges, then release with no redirects → adr=0x3000, state=RUN; after 3 edges adr=0x300C, pc4=0x3010.
2. At adr=0x3008, branch_taken=1, branch_off=0xFFFE → next adr=0x3004. With branch_off=0x0003 instead → 0x3018.
3. jump=1, jump_idx=26'h0000C10 → adr=0x00003040. In the same cycle as jr=1 with jr_target=0x3100 → adr=0x3100 (jr wins).
4. jr_target=0x3001, then separately 0x7000 with IM_WORDS=4096 → state=FAULT, pc_err=1, adr held for 5 edges; reset=0 → adr=0x3000, pc_err=0.
5. stall=1 for 3 edges with branch_taken=1 → adr unchanged. halt=1 together with stall=1 and an illegal jr → state=HALT, pc_err=0, adr frozen.
6. With IFU_FETCH_CNT_EN: 10 RUN cycles containing 2 stall cycles → fetch_cnt=8. Preload near 0xFFFFFFFF via hierarchical force → wraps to 0.
